spi_reg_bridge: RTL
===================

Name: spi_reg_bridge

Overview:
- SPI slave command controller (CPOL=0, CPHA=0 only) that decodes host frames into single 32-bit register-bus transactions.
- Sequences the frame, issues the bus request, and returns read data plus a status byte on MISO.
- Sits between the external SPI pins and the internal register file / Goertzel config bus.
- Runs entirely on the system clock; SCK is oversampled, never used as a clock.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on spi_sck, spi_ss_n and spi_mosi.
- TIMEOUT_CYC, 64, clk cycles bus_req may wait for bus_ack before the transaction is abandoned.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- spi_sck  input  1  SPI clock, asynchronous to clk
- spi_ss_n  input  1  slave select, active low
- spi_mosi  input  1  master-out data
- spi_miso  output  1  slave-out data
- bus_req  output  1  register access request
- bus_we  output  1  1=write, 0=read; valid while bus_req
- bus_addr  output  32  access address
- bus_wdata  output  32  write data
- bus_rdata  input  32  read data, valid when bus_ack
- bus_ack  input  1  one-cycle completion strobe
- bus_err  input  1  error flag, valid when bus_ack
- frame_done  output  1  one-cycle pulse at status-byte completion

Behaviour:
- Reset: all outputs 0; FSM IDLE; shift registers and status cleared.
- Clock ratio: f_clk >= 8*f_sck is a requirement.
- Edge detection on synchronized SCK:
  - Rising edge samples MOSI, MSB first.
  - Falling edge advances MISO.
  - MISO updates within SYNC_STAGES+2 clk of the SCK falling edge.
- Frame format: every field MSB first.
  - Write: instr 0x00, addr[31:0], data[31:0], dummy byte, status byte out.
  - Read: instr 0x01, addr[31:0], dummy byte, data[31:0] out, status byte out.
- FSM: IDLE -> INSTR (8 bits) -> ADDR (32) -> WDATA (32, write only) -> DUMMY (8) -> RDATA (32, read only) -> STATUS (8) -> DONE.
  - Synchronized ss_n falling edge moves IDLE -> INSTR.
  - A 6-bit bit counter is cleared at each state entry.
- Bus request issue:
  - Read: bus_req, with bus_we=0 and bus_addr, asserts on the clk after the 32nd address bit is sampled.
  - Write: bus_req, with bus_we=1, bus_addr and bus_wdata, asserts after the 32nd data bit.
  - bus_req and the qualifiers are held stable until the bus_ack cycle, then deassert the next clk.
  - Captured read data loads the MISO shift register before DUMMY ends.
- Timeout: TIMEOUT_CYC clk cycles without ack drops bus_req, sets status TIMEOUT and returns read data 0x00000000.
- Status byte:
  - bit0 ACK_OK, bit1 BUS_ERR, bit2 TIMEOUT, bit3 BAD_INSTR, bits7:4 = 0.
  - Value is frozen at the end of DUMMY.
  - If the bus is still pending at the end of DUMMY, TIMEOUT is set and the late ack is ignored.
- Bad instruction: any instr other than 0x00/0x01 sets BAD_INSTR.
  - No bus request is issued.
  - Remaining bits are ignored; MISO stays 0.
  - A full-length frame still returns status 0x08 in the byte following a 40-bit addr+dummy sequence.
- MISO: 0 outside RDATA and STATUS. In RDATA/STATUS the bit is presented before the SCK rising edge that samples it.
- Frame completion: after STATUS, extra SCK edges are ignored and MISO is 0. frame_done pulses once on the 8th status bit.
- ss_n rises mid-frame: FSM returns to IDLE and no frame_done is produced.
  - An outstanding bus_req is still held to ack or timeout; the result is discarded.
  - A new frame is accepted only after that bus transaction ends.
- Async reset mid-frame: immediate return to reset state, bus_req drops.

Test Plan:
- Write addr 0x00000010, data 0xDEADBEEF, ack after 3 clk -> one bus_req with we=1, addr 0x10, wdata 0xDEADBEEF; status 0x01; frame_done once.
- Read addr 0x00000020, ack with rdata 0x12345678 -> we=0, addr 0x20; master reads 0x12345678, status 0x01.
- Read with bus_err=1 on ack -> status 0x03; data returned as presented on bus_rdata.
- Read, bus_ack never asserted -> bus_req drops after 64 clk; data 0x00000000, status 0x04.
- Instr 0x05 -> no bus_req; status 0x08. Then ss_n raised after 16 address bits on a write: no bus_req, no frame_done, and a following read frame completes normally with status 0x01.
- rst_n asserted during WDATA -> all outputs 0 immediately; the next write frame after release completes with status 0x01.

Source files
------------

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that turns host frames into single 32-bit register-bus accesses.
// SCK, SS_N and MOSI are oversampled on clk; SCK is never used as a clock.
module spi_reg_bridge #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_sck,
  input  logic        spi_ss_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  input  logic        bus_err,
  output logic        frame_done
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {IDLE, INSTR, ADDR, WDATA, DUMMY, RDATA, STATUS, DONE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sckSync_q, ssSync_q, mosiSync_q;
  logic                   sckPrev_q, ssPrev_q;
  logic                   sckRise, sckFall, ssFall, ssHigh, mosiBit;
  logic [5:0]             bitCnt_q, bitCnt_d;
  logic [31:0]            shiftIn_q, shiftIn_d, shiftOut_q, shiftOut_d;
  logic                   instrRead_q, instrRead_d, instrBad_q, instrBad_d;
  logic [3:0]             status_q, status_d;
  logic                   discard_q, discard_d;
  logic                   busReq_q, busReq_d, busWe_q, busWe_d;
  logic [31:0]            busAddr_q, busAddr_d, busWdata_q, busWdata_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   miso_q, miso_d, frameDone_q, frameDone_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sckSync_q  <= '0;
      ssSync_q   <= '1;
      mosiSync_q <= '0;
      sckPrev_q  <= 1'b0;
      ssPrev_q   <= 1'b1;
    end else begin
      sckSync_q  <= {sckSync_q[SYNC_STAGES-2:0], spi_sck};
      ssSync_q   <= {ssSync_q[SYNC_STAGES-2:0], spi_ss_n};
      mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], spi_mosi};
      sckPrev_q  <= sckSync_q[SYNC_STAGES-1];
      ssPrev_q   <= ssSync_q[SYNC_STAGES-1];
    end
  end

  assign sckRise = sckSync_q[SYNC_STAGES-1] & ~sckPrev_q;
  assign sckFall = ~sckSync_q[SYNC_STAGES-1] & sckPrev_q;
  assign ssHigh  = ssSync_q[SYNC_STAGES-1];
  assign ssFall  = ~ssSync_q[SYNC_STAGES-1] & ssPrev_q;
  assign mosiBit = mosiSync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bitCnt_q    <= '0;
      shiftIn_q   <= '0;
      shiftOut_q  <= '0;
      instrRead_q <= 1'b0;
      instrBad_q  <= 1'b0;
      status_q    <= '0;
      discard_q   <= 1'b0;
      busReq_q    <= 1'b0;
      busWe_q     <= 1'b0;
      busAddr_q   <= '0;
      busWdata_q  <= '0;
      timer_q     <= '0;
      miso_q      <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitCnt_q    <= bitCnt_d;
      shiftIn_q   <= shiftIn_d;
      shiftOut_q  <= shiftOut_d;
      instrRead_q <= instrRead_d;
      instrBad_q  <= instrBad_d;
      status_q    <= status_d;
      discard_q   <= discard_d;
      busReq_q    <= busReq_d;
      busWe_q     <= busWe_d;
      busAddr_q   <= busAddr_d;
      busWdata_q  <= busWdata_d;
      timer_q     <= timer_d;
      miso_q      <= miso_d;
      frameDone_q <= frameDone_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bitCnt_d    = bitCnt_q;
    shiftIn_d   = shiftIn_q;
    shiftOut_d  = shiftOut_q;
    instrRead_d = instrRead_q;
    instrBad_d  = instrBad_q;
    status_d    = status_q;
    discard_d   = discard_q;
    busReq_d    = busReq_q;
    busWe_d     = busWe_q;
    busAddr_d   = busAddr_q;
    busWdata_d  = busWdata_q;
    timer_d     = timer_q;
    frameDone_d = 1'b0;

    // Bus side runs independently of the frame so an aborted frame still
    // sees its request through to ack or timeout; discard hides the result.
    if (busReq_q) begin
      if (bus_ack) begin
        busReq_d   = 1'b0;
        busWe_d    = 1'b0;
        busAddr_d  = '0;
        busWdata_d = '0;
        if (!discard_q) begin
          status_d[0] = 1'b1;
          status_d[1] = bus_err;
          if (!busWe_q) shiftOut_d = bus_rdata;
        end
      end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
        busReq_d   = 1'b0;
        busWe_d    = 1'b0;
        busAddr_d  = '0;
        busWdata_d = '0;
        if (!discard_q) begin
          status_d[2] = 1'b1;
          shiftOut_d  = '0;
        end
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end

    if (state_q inside {INSTR, ADDR, WDATA, DUMMY, RDATA, STATUS} && ssHigh) begin
      state_d   = IDLE;
      discard_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (ssFall && !busReq_q) begin
            state_d     = INSTR;
            bitCnt_d    = '0;
            status_d    = '0;
            discard_d   = 1'b0;
            shiftOut_d  = '0;
            instrRead_d = 1'b0;
            instrBad_d  = 1'b0;
          end
        end
        INSTR, ADDR, WDATA, DUMMY: begin
          if (sckRise) begin
            shiftIn_d = {shiftIn_q[30:0], mosiBit};
            bitCnt_d  = bitCnt_q + 6'd1;
            if (state_q == INSTR && bitCnt_q == 6'd7) begin
              instrRead_d = (shiftIn_d[7:0] == 8'h01);
              instrBad_d  = (shiftIn_d[7:1] != 7'd0);
              status_d[3] = instrBad_d;
              state_d     = ADDR;
              bitCnt_d    = '0;
            end else if (state_q == ADDR && bitCnt_q == 6'd31) begin
              bitCnt_d = '0;
              state_d  = DUMMY;
              if (!instrBad_q) begin
                busAddr_d = shiftIn_d;
                if (instrRead_q) begin
                  busReq_d = 1'b1;
                  busWe_d  = 1'b0;
                  timer_d  = '0;
                end else begin
                  state_d = WDATA;
                end
              end
            end else if (state_q == WDATA && bitCnt_q == 6'd31) begin
              busReq_d   = 1'b1;
              busWe_d    = 1'b1;
              busWdata_d = shiftIn_d;
              timer_d    = '0;
              bitCnt_d   = '0;
              state_d    = DUMMY;
            end else if (state_q == DUMMY && bitCnt_q == 6'd7) begin
              // Status freezes here; a still-pending access counts as timed out.
              if (busReq_d) begin
                status_d[2] = 1'b1;
                discard_d   = 1'b1;
              end
              bitCnt_d = '0;
              if (instrRead_q && !instrBad_q) begin
                state_d = RDATA;
              end else begin
                state_d    = STATUS;
                shiftOut_d = {4'b0, status_d, 24'b0};
              end
            end
          end
        end
        RDATA, STATUS: begin
          if (sckRise) begin
            bitCnt_d = bitCnt_q + 6'd1;
            if (state_q == RDATA && bitCnt_q == 6'd31) begin
              state_d    = STATUS;
              bitCnt_d   = '0;
              shiftOut_d = {4'b0, status_q, 24'b0};
            end else if (state_q == STATUS && bitCnt_q == 6'd7) begin
              state_d     = DONE;
              bitCnt_d    = '0;
              frameDone_d = 1'b1;
            end
          end else if (sckFall && bitCnt_q != 6'd0) begin
            shiftOut_d = {shiftOut_q[30:0], 1'b0};
          end
        end
        DONE: begin
          if (ssHigh) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    miso_d = (state_d == RDATA || state_d == STATUS) ? shiftOut_d[31] : 1'b0;
  end

  assign spi_miso   = miso_q;
  assign bus_req    = busReq_q;
  assign bus_we     = busWe_q;
  assign bus_addr   = busAddr_q;
  assign bus_wdata  = busWdata_q;
  assign frame_done = frameDone_q;

endmodule
